usb_serial_in_ep: RTL and testbench

Device-side IN endpoint buffer that sits between an endpoint client (such as the control endpoint or CDC data endpoint) and the USB protocol engine. The client writes one packet at a time through the req/grant/put/done interface. The protocol engine answers each IN token addressed to this endpoint with DATA0/DATA1, NAK or STALL. The block owns the packet buffer, the data toggle, retransmission on missing ACK, and the acked notification back to the client.

---
 rtl/usb_serial_in_ep.sv | 169 ++++++++++++++++
 tb/tb_usb_serial_in_ep.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_serial_in_ep.sv
// USB device IN endpoint buffer.
// Holds one outgoing packet written by the endpoint client and answers IN tokens
// with DATA0/DATA1, NAK or STALL. It owns the data toggle and replays the packet
// when the host's ACK goes missing.
module usb_serial_in_ep #(
   parameter int MAX_PKT_SIZE = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_ep_req,
   output logic       in_ep_grant,
   output logic       in_ep_data_free,
   input  logic       in_ep_data_put,
   input  logic [7:0] in_ep_data,
   input  logic       in_ep_data_done,
   input  logic       in_ep_stall,
   output logic       in_ep_acked,
   input  logic       setup_token,
   input  logic       in_token_valid,
   input  logic       rx_ack,
   output logic       tx_pkt_start,
   output logic [3:0] tx_pid,
   output logic       tx_data_avail,
   input  logic       tx_data_get,
   output logic [7:0] tx_data
);

   localparam int AW = $clog2(MAX_PKT_SIZE);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_SIZE);

   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_READY,
      ST_SEND,
      ST_WAIT_ACK
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic          toggle_q, toggle_d;
   logic          acked_q, acked_d;
   logic          start_q, start_d;
   logic [3:0]    pid_q, pid_d;
   logic          wr_en;
   logic [3:0]    data_pid;

   logic [7:0]    mem [MAX_PKT_SIZE];

   assign in_ep_grant     = in_ep_req && (state_q == ST_FILL);
   assign in_ep_data_free = in_ep_grant && (wr_cnt_q < MAX_CNT);
   assign tx_data_avail   = (state_q == ST_SEND) && (rd_ptr_q < wr_cnt_q);
   // Gate the read so the byte lane is quiet whenever no payload is on offer.
   assign tx_data         = tx_data_avail ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
   assign in_ep_acked     = acked_q;
   assign tx_pkt_start    = start_q;
   assign tx_pid          = pid_q;
   assign data_pid        = toggle_q ? PID_DATA1 : PID_DATA0;

   // Next-state logic: SETUP overrides everything, otherwise act on the current state.
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_ptr_d = rd_ptr_q;
      toggle_d = toggle_q;
      pid_d    = pid_q;
      acked_d  = 1'b0;
      start_d  = 1'b0;
      wr_en    = 1'b0;
      if (setup_token) begin
         // New control transfer: drop anything buffered, first data stage is DATA1.
         wr_cnt_d = '0;
         rd_ptr_d = '0;
         toggle_d = 1'b1;
         state_d  = ST_FILL;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (in_ep_data_put && in_ep_data_free) begin
                  wr_en    = 1'b1;
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end
               // Close on explicit done or as soon as the buffer is full.
               if (in_ep_data_done || (wr_cnt_d == MAX_CNT)) begin
                  state_d = ST_READY;
               end
               if (in_token_valid) begin
                  start_d = 1'b1;
                  pid_d   = in_ep_stall ? PID_STALL : PID_NAK;
               end
            end
            ST_READY: begin
               if (in_token_valid) begin
                  start_d = 1'b1;
                  if (in_ep_stall) begin
                     pid_d = PID_STALL;
                  end else begin
                     pid_d    = data_pid;
                     rd_ptr_d = '0;
                     state_d  = ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               // Tokens are ignored here; a ZLP leaves on the cycle after entry.
               if (rd_ptr_q == wr_cnt_q) begin
                  state_d = ST_WAIT_ACK;
               end else if (tx_data_get) begin
                  rd_ptr_d = rd_ptr_q + CW'(1);
               end
            end
            ST_WAIT_ACK: begin
               if (rx_ack) begin
                  toggle_d = ~toggle_q;
                  acked_d  = 1'b1;
                  wr_cnt_d = '0;
                  state_d  = ST_FILL;
               end else if (in_token_valid) begin
                  // Host never saw our data or we never saw its ACK: replay as-is.
                  start_d = 1'b1;
                  if (in_ep_stall) begin
                     pid_d = PID_STALL;
                  end else begin
                     pid_d    = data_pid;
                     rd_ptr_d = '0;
                     state_d  = ST_SEND;
                  end
               end
            end
            default: state_d = ST_FILL;
         endcase
      end
   end

   // Control and registered-output flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_FILL;
         wr_cnt_q <= '0;
         rd_ptr_q <= '0;
         toggle_q <= 1'b0;
         acked_q  <= 1'b0;
         start_q  <= 1'b0;
         pid_q    <= 4'b0000;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_ptr_q <= rd_ptr_d;
         toggle_q <= toggle_d;
         acked_q  <= acked_d;
         start_q  <= start_d;
         pid_q    <= pid_d;
      end
   end

   // Packet buffer write port; contents need no reset since wr_cnt bounds every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_cnt_q[AW-1:0]] <= in_ep_data;
      end
   end

endmodule

// File: tb/tb_usb_serial_in_ep.sv
// Testbench for usb_serial_in_ep: table of packets plus hand-written corner sequences.
module tb_usb_serial_in_ep;

   localparam int MAX = 32;
   localparam logic [3:0] P_D0    = 4'b0011;
   localparam logic [3:0] P_D1    = 4'b1011;
   localparam logic [3:0] P_NAK   = 4'b1010;
   localparam logic [3:0] P_STALL = 4'b1110;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_ep_req = 1'b0;
   logic       in_ep_grant;
   logic       in_ep_data_free;
   logic       in_ep_data_put = 1'b0;
   logic [7:0] in_ep_data = 8'h00;
   logic       in_ep_data_done = 1'b0;
   logic       in_ep_stall = 1'b0;
   logic       in_ep_acked;
   logic       setup_token = 1'b0;
   logic       in_token_valid = 1'b0;
   logic       rx_ack = 1'b0;
   logic       tx_pkt_start;
   logic [3:0] tx_pid;
   logic       tx_data_avail;
   logic       tx_data_get = 1'b0;
   logic [7:0] tx_data;

   usb_serial_in_ep #(.MAX_PKT_SIZE(MAX)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_ep_req      (in_ep_req),
      .in_ep_grant    (in_ep_grant),
      .in_ep_data_free(in_ep_data_free),
      .in_ep_data_put (in_ep_data_put),
      .in_ep_data     (in_ep_data),
      .in_ep_data_done(in_ep_data_done),
      .in_ep_stall    (in_ep_stall),
      .in_ep_acked    (in_ep_acked),
      .setup_token    (setup_token),
      .in_token_valid (in_token_valid),
      .rx_ack         (rx_ack),
      .tx_pkt_start   (tx_pkt_start),
      .tx_pid         (tx_pid),
      .tx_data_avail  (tx_data_avail),
      .tx_data_get    (tx_data_get),
      .tx_data        (tx_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb[$];        // bytes the client has written, awaiting transmission
   logic [7:0] last_pkt[$];  // bytes of the most recent packet, for replay comparison
   bit exp_toggle = 1'b0;

   typedef struct {
      bit         setup;
      int         n;
      bit         done;
      logic [3:0] pid;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_setup();
      setup_token = 1'b1;
      step();
      setup_token = 1'b0;
      sb.delete();
      exp_toggle = 1'b1;
      #1;
      check("acked_after_setup", 32'(in_ep_acked), 32'd0);
   endtask

   // Write n bytes; with done, the last put carries done (or a lone done for n==0).
   task automatic fill(input int n, input bit done, input bit close_chk);
      in_ep_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         in_ep_data_put  = 1'b1;
         in_ep_data      = (i == 0) ? 8'h12 : 8'(i * 7 + n);
         in_ep_data_done = done && (i == n - 1);
         #1;
         check("data_free", 32'(in_ep_data_free), 32'd1);
         sb.push_back(in_ep_data);
         step();
      end
      if (n == 0 && done) begin
         in_ep_data_done = 1'b1;
         step();
      end
      in_ep_data_put  = 1'b0;
      in_ep_data_done = 1'b0;
      if (close_chk) begin
         #1;
         check("free_after_close", 32'(in_ep_data_free), 32'd0);
         check("grant_after_close", 32'(in_ep_grant), 32'd0);
      end
   endtask

   // IN token then drain the payload, comparing against scoreboard or replay copy.
   task automatic send_in(input logic [3:0] pid, input int len, input bit resend);
      int k = 0;
      int guard = 0;
      logic [7:0] exp;
      in_token_valid = 1'b1;
      step();
      in_token_valid = 1'b0;
      #1;
      check("tx_pkt_start", 32'(tx_pkt_start), 32'd1);
      check("tx_pid", 32'(tx_pid), 32'(pid));
      check("avail_first", 32'(tx_data_avail), 32'(len > 0));
      if (!resend) last_pkt.delete();
      while (tx_data_avail && guard < 2 * MAX) begin
         guard++;
         if (resend) begin
            if (k < last_pkt.size()) exp = last_pkt[k];
            else exp = ~tx_data;
         end else begin
            if (sb.size() > 0) begin
               exp = sb.pop_front();
               last_pkt.push_back(exp);
            end else begin
               exp = ~tx_data;
            end
         end
         check(resend ? "tx_data_resend" : "tx_data", 32'(tx_data), 32'(exp));
         tx_data_get = 1'b1;
         step();
         tx_data_get = 1'b0;
         #1;
         k++;
      end
      check("pkt_len", 32'(k), 32'(len));
      step();
      check("start_done", 32'(tx_pkt_start), 32'd0);
      check("avail_done", 32'(tx_data_avail), 32'd0);
      $display("packet pid=%0h len=%0d resend=%0d", pid, k, resend);
   endtask

   task automatic ack();
      in_ep_req = 1'b1;
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
      #1;
      check("acked_pulse", 32'(in_ep_acked), 32'd1);
      check("grant_after_ack", 32'(in_ep_grant), 32'd1);
      step();
      check("acked_single", 32'(in_ep_acked), 32'd0);
      exp_toggle = ~exp_toggle;
   endtask

   task automatic handshake_in(input logic [3:0] pid);
      in_token_valid = 1'b1;
      step();
      in_token_valid = 1'b0;
      #1;
      check("hs_start", 32'(tx_pkt_start), 32'd1);
      check("hs_pid", 32'(tx_pid), 32'(pid));
      check("hs_avail", 32'(tx_data_avail), 32'd0);
      step();
      check("hs_start_end", 32'(tx_pkt_start), 32'd0);
      check("hs_avail_end", 32'(tx_data_avail), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 32'(in_ep_grant), 32'd0);
      check({tag, "_free"}, 32'(in_ep_data_free), 32'd0);
      check({tag, "_acked"}, 32'(in_ep_acked), 32'd0);
      check({tag, "_start"}, 32'(tx_pkt_start), 32'd0);
      check({tag, "_pid"}, 32'(tx_pid), 32'd0);
      check({tag, "_avail"}, 32'(tx_data_avail), 32'd0);
      check({tag, "_data"}, 32'(tx_data), 32'd0);
   endtask

   initial begin
      // setup, bytes, close with done, expected PID
      vecs[0] = '{setup: 1'b1, n: 18,  done: 1'b1, pid: P_D1};
      vecs[1] = '{setup: 1'b1, n: MAX, done: 1'b0, pid: P_D1};
      vecs[2] = '{setup: 1'b0, n: MAX, done: 1'b0, pid: P_D0};
      vecs[3] = '{setup: 1'b0, n: 3,   done: 1'b1, pid: P_D1};
      vecs[4] = '{setup: 1'b0, n: 0,   done: 1'b1, pid: P_D0};

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      step();

      // Table: 18-byte packet, then 67-byte stream split 32/32/3, then ZLP.
      foreach (vecs[v]) begin
         if (vecs[v].setup) do_setup();
         fill(vecs[v].n, vecs[v].done, 1'b1);
         if (vecs[v].n == MAX) begin
            // Extra put after auto-close must be ignored.
            in_ep_data_put = 1'b1;
            in_ep_data = 8'hAA;
            step();
            in_ep_data_put = 1'b0;
         end
         send_in(vecs[v].pid, vecs[v].n, 1'b0);
         ack();
      end

      // NAK while filling, then finish the packet; lost ACK forces a replay.
      fill(5, 1'b0, 1'b0);
      handshake_in(P_NAK);
      check("free_after_nak", 32'(in_ep_data_free), 32'd1);
      fill(2, 1'b1, 1'b1);
      send_in(exp_toggle ? P_D1 : P_D0, 7, 1'b0);
      send_in(exp_toggle ? P_D1 : P_D0, 7, 1'b1);
      ack();

      // ZLP, then STALL with a buffered packet, then release.
      fill(0, 1'b1, 1'b1);
      send_in(exp_toggle ? P_D1 : P_D0, 0, 1'b0);
      ack();
      fill(4, 1'b1, 1'b1);
      in_ep_stall = 1'b1;
      handshake_in(P_STALL);
      in_ep_stall = 1'b0;
      send_in(exp_toggle ? P_D1 : P_D0, 4, 1'b0);
      ack();

      // SETUP mid-fill with a simultaneous put that must be dropped.
      fill(5, 1'b0, 1'b0);
      in_ep_data_put = 1'b1;
      in_ep_data = 8'hEE;
      do_setup();
      in_ep_data_put = 1'b0;
      step();
      check("acked_after_setup2", 32'(in_ep_acked), 32'd0);
      fill(3, 1'b1, 1'b1);
      in_token_valid = 1'b1;
      step();
      in_token_valid = 1'b0;
      #1;
      check("setup_pid", 32'(tx_pid), 32'(P_D1));
      check("setup_avail", 32'(tx_data_avail), 32'd1);
      check("setup_byte0", 32'(tx_data), 32'(sb[0]));
      tx_data_get = 1'b1;
      step();
      tx_data_get = 1'b0;

      // Asynchronous reset in the middle of SEND.
      in_ep_req = 1'b0;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      step();
      reset_n = 1'b1;
      sb.delete();
      exp_toggle = 1'b0;
      step();
      fill(2, 1'b1, 1'b1);
      send_in(exp_toggle ? P_D1 : P_D0, 2, 1'b0);
      ack();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the bench always ends.
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
